// File: rtl/analyzer_capture_pkg.sv
// Shared types and defaults for the logic-analyzer capture front-end.
// Holds the capture state enum, default widths and trigger-match constants.
// No logic of its own; imported by analyzer_capture and analyzer_trig_match.
package analyzer_capture_pkg;

    // Default widths: probe/FIFO word, FIFO address, sample divider.
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned DEPTH_WIDTH_DEF = 13;
    localparam int unsigned DIV_WIDTH_DEF   = 16;

    // Trigger-match result encoding shared by the matcher and its user.
    localparam logic MATCH_HIT  = 1'b1;
    localparam logic MATCH_MISS = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // The sample divider and the busy flag run only in the capturing states.
    function automatic logic is_busy(state_e st);
        return (st == ST_PRE) || (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/analyzer_trig_match.sv
// Trigger matcher: compares a sample against mask/value, optionally edge-qualified.
// Latency: purely combinational.
// Optional feature macro ANALYZER_CAPTURE_EDGE_TRIG_EN adds edge_i/s_prev_i/prev_vld_i.
module analyzer_trig_match
    import analyzer_capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] s_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    input  logic [DATA_WIDTH-1:0] value_i,
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
    input  logic [DATA_WIDTH-1:0] edge_i,
    input  logic [DATA_WIDTH-1:0] s_prev_i,
    input  logic                  prev_vld_i,
`endif
    output logic                  match_o
);

    logic [DATA_WIDTH-1:0] miss_bits;

    // A masked bit misses if its level differs; edge bits also need a fresh transition.
    always_comb begin
        miss_bits = (s_i ^ value_i) & mask_i;
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        // Without a valid previous sample no edge can be proven, so edge bits miss.
        miss_bits = miss_bits
                  | (mask_i & edge_i & ~({DATA_WIDTH{prev_vld_i}} & (s_i ^ s_prev_i)));
`endif
        match_o = (miss_bits == '0) ? MATCH_HIT : MATCH_MISS;
    end

endmodule

// File: rtl/analyzer_capture.sv
// Logic-analyzer capture: samples probe at a divided rate, keeps a pre-trigger window, writes post-trigger samples.
// Latency: tick to FIFO write is 2 cycles; done rises the cycle after the last post write.
// No backpressure: a write due while fifo_wr_full is dropped and flagged in overrun. Macro: ANALYZER_CAPTURE_EDGE_TRIG_EN.
module analyzer_capture
    import analyzer_capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH_WIDTH = DEPTH_WIDTH_DEF,
    parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DATA_WIDTH-1:0]  probe,
    input  logic [DATA_WIDTH-1:0]  trig_mask,
    input  logic [DATA_WIDTH-1:0]  trig_value,
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
    input  logic [DATA_WIDTH-1:0]  trig_edge,
`endif
    input  logic [DEPTH_WIDTH-1:0] pre_cnt,
    input  logic [DEPTH_WIDTH-1:0] post_cnt,
    input  logic [DIV_WIDTH-1:0]   sample_div,
    output logic                   fifo_wr_en,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    output logic                   fifo_rd_en,
    input  logic                   fifo_wr_full,
    input  logic                   fifo_empty,
    output logic                   busy,
    output logic                   triggered,
    output logic                   done,
    output logic                   overrun
);

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DATA_WIDTH-1:0]  s_q;
    logic                   s_vld_q;
    logic [DEPTH_WIDTH-1:0] fill_q, fill_d;
    logic [DEPTH_WIDTH-1:0] post_left_q, post_left_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   rd_en_q, rd_en_d;
    logic                   trig_q, trig_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, done_q;
    logic                   tick;
    logic                   match;
    logic                   write_due;

    assign tick = is_busy(state_q) && (div_q == sample_div);

    // Divider restarts from zero whenever capture is not running and after each tick.
    always_comb begin
        div_d = (!is_busy(state_q) || tick) ? '0 : div_q + 1'b1;
    end

`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
    logic [DATA_WIDTH-1:0] s_prev_q;
    logic                  prev_vld_q;

    // Previous ARMED sample for edge detection; invalid on the first ARMED sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_prev_q   <= '0;
            prev_vld_q <= 1'b0;
        end else if (state_q != ST_ARMED) begin
            prev_vld_q <= 1'b0;
        end else if (s_vld_q) begin
            s_prev_q   <= s_q;
            prev_vld_q <= 1'b1;
        end
    end
`endif

    analyzer_trig_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .s_i        (s_q),
        .mask_i     (trig_mask),
        .value_i    (trig_value),
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        .edge_i     (trig_edge),
        .s_prev_i   (s_prev_q),
        .prev_vld_i (prev_vld_q),
`endif
        .match_o    (match)
    );

    // Capture FSM next state; abort overrides start and the trigger.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        post_left_d = post_left_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        trig_d      = trig_q;
        ovr_d       = ovr_q;
        write_due   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = (pre_cnt == '0) ? ST_ARMED : ST_PRE;
                        fill_d  = '0;
                        trig_d  = 1'b0;
                        ovr_d   = 1'b0;
                    end
                end
                ST_PRE: begin
                    if (s_vld_q) begin
                        write_due = 1'b1;
                        fill_d    = fill_q + 1'b1;
                        if ((fill_q + 1'b1) == pre_cnt) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (s_vld_q) begin
                        if (match == MATCH_HIT) begin
                            write_due   = 1'b1;
                            trig_d      = 1'b1;
                            post_left_d = post_cnt;
                            state_d     = (post_cnt == '0) ? ST_DONE : ST_POST;
                        end else if (pre_cnt != '0) begin
                            // Slide the pre-trigger window: add newest, drop oldest.
                            write_due = 1'b1;
                            rd_en_d   = !fifo_empty;
                        end
                    end
                end
                ST_POST: begin
                    if (s_vld_q) begin
                        write_due   = 1'b1;
                        post_left_d = post_left_q - 1'b1;
                        if (post_left_q == DEPTH_WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A full FIFO loses the sample but the counters still advance.
        if (write_due) begin
            if (fifo_wr_full) begin
                ovr_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = s_q;
            end
        end
    end

    // Sample register, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            s_q         <= '0;
            s_vld_q     <= 1'b0;
            fill_q      <= '0;
            post_left_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            trig_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            s_vld_q     <= tick;
            if (tick) begin
                s_q <= probe;
            end
            fill_q      <= fill_d;
            post_left_q <= post_left_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            trig_q      <= trig_d;
            ovr_q       <= ovr_d;
            busy_q      <= is_busy(state_d);
            // done trails entry to DONE by one cycle so it follows the last write.
            done_q      <= (state_q == ST_DONE) && (state_d == ST_DONE);
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_en_q;
    assign busy         = busy_q;
    assign triggered    = trig_q;
    assign done         = done_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_analyzer_capture.sv
// Bench for analyzer_capture: FIFO model plus write scoreboard against a sample-level reference.
// Expected writes are queued per capture; a negedge monitor pops and compares them.
// Edge-trigger case is included when ANALYZER_CAPTURE_EDGE_TRIG_EN is defined.
module tb_analyzer_capture;

    localparam int DW = 32;
    localparam int AW = 13;
    localparam int VW = 16;
    localparam int PM = 8192;
    localparam int FIFO_DEPTH = 8192;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, abort;
    logic [DW-1:0] probe, trig_mask, trig_value;
    logic [AW-1:0] pre_cnt, post_cnt;
    logic [VW-1:0] sample_div;
    logic          fifo_wr_en, fifo_rd_en, fifo_wr_full;
    logic          fifo_empty = 1'b1;
    logic          model_full = 1'b0;
    logic          force_full;
    logic [DW-1:0] fifo_wr_data;
    logic          busy, triggered, done, overrun;
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
    logic [DW-1:0] trig_edge;
`endif

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] pmem [0:PM-1];
    logic [DW-1:0] fifo_m [$];
    exp_t          exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_wr_full = model_full || force_full;

    analyzer_capture dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .probe        (probe),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        .trig_edge    (trig_edge),
`endif
        .pre_cnt      (pre_cnt),
        .post_cnt     (post_cnt),
        .sample_div   (sample_div),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_wr_full (fifo_wr_full),
        .fifo_empty   (fifo_empty),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .overrun      (overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model and write monitor; flags seen by the DUT reflect operations of earlier cycles.
    always @(negedge clk) begin : mon
        exp_t e;
        fifo_empty = (fifo_m.size() == 0);
        model_full = (fifo_m.size() >= FIFO_DEPTH);
        if (rstn) begin
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write of %0h at cycle %0d, required no write", fifo_wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                    check("write_data", 64'(fifo_wr_data), 64'(e.dat));
                end
                fifo_m.push_back(fifo_wr_data);
            end
            if (fifo_rd_en) begin
                check("rd_en_on_empty", 64'(fifo_m.size() == 0), 64'(0));
                if (fifo_m.size() != 0) void'(fifo_m.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        force_full = 1'b0;
        probe      = pmem[cyc % PM];
    endtask

    function automatic int tk(input int c0, input int div, input int n);
        return c0 + 1 + div + n * (div + 1);
    endfunction

    function automatic logic [31:0] smp(input int c0, input int div, input int n);
        return pmem[tk(c0, div, n) % PM];
    endfunction

    // Reference trigger rule evaluated bit by bit.
    function automatic bit ref_match(input logic [31:0] s, input logic [31:0] sp, input bit pv,
                                     input logic [31:0] m, input logic [31:0] v, input logic [31:0] e);
        for (int b = 0; b < DW; b++) begin
            if (m[b]) begin
                if (e[b]) begin
                    if (!(pv && (sp[b] != s[b]) && (s[b] == v[b]))) return 1'b0;
                end else if (s[b] != v[b]) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    // mode 0 random, 1 counting, 2 abort pattern (0x55 at abort_m), 3 edge pattern.
    function automatic logic [31:0] gen(input int mode, input int n, input int abort_m);
        logic [31:0] r;
        r = $urandom;
        case (mode)
            1: r = 32'(n);
            2: begin
                if (r[7:0] == 8'h55) r[7:0] = 8'h54;
                if (n == abort_m) r[7:0] = 8'h55;
            end
            3: r = (n == 5) ? 32'h0 : 32'h1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic run_capture(input int mode, input int div, input int pre, input int post,
                               input logic [31:0] mask, input logic [31:0] value, input logic [31:0] edg,
                               input int full_off, input int abort_m);
        int c0, k, first, last, lo, hi, ns, t_end, done_cyc, fa, fb;
        bit pv;
        bit aborted;
        logic [31:0] win [$];
        logic [31:0] s;
        aborted = (abort_m >= 0);
        step();
        c0 = cyc;
        ns = pre + post + 48;
        for (int n = 0; n < ns; n++) begin
            for (int j = 0; j < div; j++) pmem[(c0 + 1 + n * (div + 1) + j) % PM] = $urandom;
            pmem[tk(c0, div, n) % PM] = gen(mode, n, abort_m);
        end
        k  = -1;
        pv = 1'b0;
        if (!aborted) begin
            for (int n = pre; n < ns - post - 1; n++) begin
                if (ref_match(smp(c0, div, n), (n > 0) ? smp(c0, div, n - 1) : 32'h0, pv, mask, value, edg)) begin
                    k = n;
                    break;
                end
                pv = 1'b1;
            end
            if (k < 0) begin
                k = pre + 5;
                s = smp(c0, div, k);
                pmem[tk(c0, div, k) % PM] = (s & ~mask) | (value & mask);
            end
            last = k + post;
            first = (pre > 0) ? 0 : k;
            lo = k - pre;
        end else begin
            last  = abort_m - 1;
            first = (pre > 0) ? 0 : abort_m;
            lo    = abort_m - pre;
        end
        hi = last;
        fa = (full_off > 0) ? k + full_off : -10;
        fb = (full_off > 0) ? k + full_off + 1 : -10;
        for (int n = first; n <= last; n++)
            if (n != fa && n != fb) exp_q.push_back('{tk(c0, div, n) + 2, smp(c0, div, n)});
        for (int n = lo; n <= hi; n++)
            if (n != fa && n != fb) win.push_back(smp(c0, div, n));

        trig_mask  = mask;
        trig_value = value;
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        trig_edge  = edg;
`endif
        pre_cnt    = pre[AW-1:0];
        post_cnt   = post[AW-1:0];
        sample_div = div[VW-1:0];
        start      = 1'b1;

        done_cyc = -1;
        t_end = aborted ? tk(c0, div, abort_m) + 8 : tk(c0, div, last) + 6;
        while (cyc < t_end) begin
            step();
            if (cyc == tk(c0, div, fa) + 1 || cyc == tk(c0, div, fb) + 1) force_full = 1'b1;
            if (aborted && cyc == tk(c0, div, abort_m) + 1) begin
                abort = 1'b1;
                start = 1'b1;
            end
            if (cyc == c0 + 1) check("busy_after_start", 64'(busy), 64'(1));
            if (aborted && cyc == tk(c0, div, abort_m) + 2) begin
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_triggered", 64'(triggered), 64'(0));
                check("abort_done", 64'(done), 64'(0));
            end
            if (!aborted && cyc == tk(c0, div, k) + 1) check("triggered_before", 64'(triggered), 64'(0));
            if (!aborted && cyc == tk(c0, div, k) + 2) check("triggered_at_write", 64'(triggered), 64'(1));
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        if (!aborted) begin
            check("done_cycle", 64'(done_cyc), 64'(tk(c0, div, last) + 3));
            check("done_level", 64'(done), 64'(1));
            check("overrun", 64'(overrun), 64'(full_off > 0));
        end else begin
            check("no_done_after_abort", 64'(done_cyc), 64'(-1));
        end
        check("busy_end", 64'(busy), 64'(0));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        check("fifo_words", 64'(fifo_m.size()), 64'(win.size()));
        for (int i = 0; i < win.size() && i < fifo_m.size(); i++)
            check("fifo_content", 64'(fifo_m[i]), 64'(win[i]));
        exp_q.delete();
        fifo_m.delete();
        step();
        step();
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        force_full = 1'b0;
        probe      = '0;
        trig_mask  = '0;
        trig_value = '0;
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        trig_edge  = '0;
`endif
        pre_cnt    = '0;
        post_cnt   = '0;
        sample_div = '0;
        for (int i = 0; i < PM; i++) pmem[i] = $urandom;
        step();
        step();
        check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_wr_data", 64'(fifo_wr_data), 64'(0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_triggered", 64'(triggered), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        rstn = 1'b1;
        step();
        step();

        // Counting probe: window 0x26..0x2D around trigger 0x2A.
        run_capture(1, 0, 4, 3, 32'hFF, 32'h2A, 32'h0, 0, -1);
        // Divided sampling: writes every 4 cycles.
        run_capture(0, 3, 3, 4, 32'hF, $urandom, 32'h0, 0, -1);
        // No pre window, mask 0, no post: exactly one word.
        run_capture(0, 0, 0, 0, 32'h0, $urandom, 32'h0, 0, -1);
        // Full during two post ticks: two words lost, overrun set, done on time.
        run_capture(0, 0, 3, 5, 32'h3, $urandom, 32'h0, 2, -1);
        // Abort together with a matching sample and a start pulse.
        run_capture(2, 0, 2, 2, 32'hFF, 32'h55, 32'h0, 0, 6);
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        // Held level never triggers on an edge bit; a 0->1 transition does.
        run_capture(3, 0, 0, 1, 32'h1, 32'h1, 32'h1, 0, -1);
`endif
        for (int r = 0; r < 8; r++)
            run_capture(0, $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 10),
                        32'($urandom_range(0, 15)), $urandom, 32'h0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
